// File: rtl/car_passage_pkg.sv
// Shared definitions for the parking-gate passage generator: request kinds,
// sequencer states and the beam pattern of every phase.
package car_passage_pkg;

    localparam logic [1:0] KIND_ENTER    = 2'b00;
    localparam logic [1:0] KIND_EXIT     = 2'b01;
    localparam logic [1:0] KIND_BALK_IN  = 2'b10;
    localparam logic [1:0] KIND_BALK_OUT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_P1   = 3'd1,
        ST_P2   = 3'd2,
        ST_P3   = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

    // Returns {sensor_a, sensor_b}; only one beam differs between neighbouring phases.
    function automatic logic [1:0] phase_ab(input logic [1:0] kind, input state_t st);
        logic [1:0] ab;
        ab = 2'b00;
        case (st)
            ST_P1: begin
                case (kind)
                    KIND_ENTER:    ab = 2'b10;
                    KIND_EXIT:     ab = 2'b01;
                    KIND_BALK_IN:  ab = 2'b10;
                    KIND_BALK_OUT: ab = 2'b01;
                    default:       ab = 2'b00;
                endcase
            end
            ST_P2: ab = 2'b11;
            ST_P3: begin
                case (kind)
                    KIND_ENTER:    ab = 2'b01;
                    KIND_EXIT:     ab = 2'b10;
                    KIND_BALK_IN:  ab = 2'b10;
                    KIND_BALK_OUT: ab = 2'b01;
                    default:       ab = 2'b00;
                endcase
            end
            default: ab = 2'b00;
        endcase
        return ab;
    endfunction

endpackage

// File: rtl/car_passage_gen_dwell_timer.sv
// Loadable down-counter timing the dwell of each phase and of the trailing gap.
module passage_dwell_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    // Load on every state change, otherwise count down and rest at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/car_passage_gen.sv
// Drives one two-beam passage pattern per accepted request and tallies
// completed enters and exits for a downstream scoreboard.
module car_passage_gen #(
    parameter int PHASE_CYCLES = 1,
    parameter int GAP_CYCLES   = 1,
    parameter int CNT_W        = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [1:0]       req_kind,
    output logic             req_ready,
    output logic             sensor_a,
    output logic             sensor_b,
    output logic             busy,
    output logic             done,
    output logic [1:0]       done_kind,
    output logic [CNT_W-1:0] enter_cnt,
    output logic [CNT_W-1:0] exit_cnt
);
    import car_passage_pkg::*;

    localparam int DWELL_MAX = (PHASE_CYCLES > GAP_CYCLES) ? PHASE_CYCLES : GAP_CYCLES;
    localparam int TW        = $clog2(DWELL_MAX + 1);
    localparam logic [TW-1:0] PHASE_LOAD = TW'(PHASE_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_kind;
    logic [1:0]       w_kind_nxt;
    logic [1:0]       w_ab_nxt;
    logic             w_accept;
    logic             w_complete;
    logic             w_tc;
    logic             w_load;
    logic [TW-1:0]    w_load_val;
    logic             r_sensor_a;
    logic             r_sensor_b;
    logic             r_busy;
    logic             r_done;
    logic [1:0]       r_done_kind;
    logic [CNT_W-1:0] r_enter_cnt;
    logic [CNT_W-1:0] r_exit_cnt;

    passage_dwell_timer #(
        .W (TW)
    ) u_dwell (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_tc       (w_tc)
    );

    // Next-state decode: each phase advances once its dwell has expired.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_P1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_P1: w_state_nxt = w_tc ? ST_P2 : ST_P1;
            ST_P2: w_state_nxt = w_tc ? ST_P3 : ST_P2;
            ST_P3: w_state_nxt = w_tc ? ST_GAP : ST_P3;
            ST_GAP: begin
                if (w_tc) begin
                    w_complete  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_GAP;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Beam values are looked up for the state being entered so they are registered with it.
    always_comb begin
        w_kind_nxt = w_accept ? req_kind : r_kind;
        w_ab_nxt   = phase_ab(w_kind_nxt, w_state_nxt);
        w_load     = (w_state_nxt != r_state);
        w_load_val = (w_state_nxt == ST_GAP) ? GAP_LOAD : PHASE_LOAD;
    end

    // Sequencer state, latched kind and registered beam outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_kind     <= KIND_ENTER;
            r_sensor_a <= 1'b0;
            r_sensor_b <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_kind     <= w_kind_nxt;
            r_sensor_a <= w_ab_nxt[1];
            r_sensor_b <= w_ab_nxt[0];
            r_busy     <= (w_state_nxt != ST_IDLE);
        end
    end

    // Completion pulse and passage tallies; balks leave both tallies alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done      <= 1'b0;
            r_done_kind <= KIND_ENTER;
            r_enter_cnt <= '0;
            r_exit_cnt  <= '0;
        end else begin
            r_done <= w_complete;
            if (w_complete) begin
                r_done_kind <= r_kind;
            end else begin
                r_done_kind <= r_done_kind;
            end
            if (w_complete && (r_kind == KIND_ENTER)) begin
                r_enter_cnt <= r_enter_cnt + CNT_W'(1);
            end else begin
                r_enter_cnt <= r_enter_cnt;
            end
            if (w_complete && (r_kind == KIND_EXIT)) begin
                r_exit_cnt <= r_exit_cnt + CNT_W'(1);
            end else begin
                r_exit_cnt <= r_exit_cnt;
            end
        end
    end

    assign req_ready = (r_state == ST_IDLE) && !reset;
    assign sensor_a  = r_sensor_a;
    assign sensor_b  = r_sensor_b;
    assign busy      = r_busy;
    assign done      = r_done;
    assign done_kind = r_done_kind;
    assign enter_cnt = r_enter_cnt;
    assign exit_cnt  = r_exit_cnt;

endmodule

// File: tb/tb_car_passage_gen.sv
// Directed bench for car_passage_gen: a default instance (dwell 1/1) and a
// slow instance (dwell 3/2) used for the long-dwell and tally-wrap scenario.
module tb_car_passage_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       v1, v2;
    logic [1:0] k1, k2;
    logic       r1, a1, b1, busy1, done1;
    logic       r2, a2, b2, busy2, done2;
    logic [1:0] dk1, dk2;
    logic [2:0] ec1, xc1, ec2, xc2;

    int total = 0;
    int bad   = 0;

    car_passage_gen dut1 (
        .clk(clk), .reset(reset), .req_valid(v1), .req_kind(k1), .req_ready(r1),
        .sensor_a(a1), .sensor_b(b1), .busy(busy1), .done(done1), .done_kind(dk1),
        .enter_cnt(ec1), .exit_cnt(xc1)
    );

    car_passage_gen #(.PHASE_CYCLES(3), .GAP_CYCLES(2), .CNT_W(3)) dut2 (
        .clk(clk), .reset(reset), .req_valid(v2), .req_kind(k2), .req_ready(r2),
        .sensor_a(a2), .sensor_b(b2), .busy(busy2), .done(done2), .done_kind(dk2),
        .enter_cnt(ec2), .exit_cnt(xc2)
    );

    // Expected {a,b} per kind; ph 0..2 are P1..P3, anything else is gap/idle.
    function automatic logic [1:0] exp_ab(input logic [1:0] kind, input int ph);
        logic [1:0] ab;
        ab = 2'b00;
        if (ph == 0) begin
            case (kind)
                2'b00: ab = 2'b10;
                2'b01: ab = 2'b01;
                2'b10: ab = 2'b10;
                default: ab = 2'b01;
            endcase
        end else if (ph == 1) begin
            ab = 2'b11;
        end else if (ph == 2) begin
            case (kind)
                2'b00: ab = 2'b01;
                2'b01: ab = 2'b10;
                2'b10: ab = 2'b10;
                default: ab = 2'b01;
            endcase
        end
        return ab;
    endfunction

    // Advance one clock and land on the falling edge for sampling/driving.
    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1; v1 = 1'b0; k1 = 2'b00; v2 = 1'b0; k2 = 2'b00;
        step();
        step();
        total++;
        if ({r1, r2} !== 2'b00) begin
            bad++; $display("FAIL reset_ready_low: got %b expected 00", {r1, r2});
        end
        reset = 1'b0;
        step();
        total++;
        if ({a1, b1, r1, busy1, done1, dk1, ec1, xc1} !== {2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 3'd0, 3'd0}) begin
            bad++; $display("FAIL reset_state_dut1: got %h", {a1, b1, r1, busy1, done1, dk1, ec1, xc1});
        end
        total++;
        if ({a2, b2, r2, busy2, done2, dk2, ec2, xc2} !== {2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 3'd0, 3'd0}) begin
            bad++; $display("FAIL reset_state_dut2: got %h", {a2, b2, r2, busy2, done2, dk2, ec2, xc2});
        end
    endtask

    task automatic test_enter;
        v1 = 1'b1; k1 = 2'b00;
        #1;
        total++;
        if (r1 !== 1'b1) begin
            bad++; $display("FAIL enter_ready: got %b expected 1", r1);
        end
        for (int c = 0; c < 4; c++) begin
            step();
            if (c == 0) v1 = 1'b0;
            total++;
            if ({a1, b1, busy1, done1} !== {exp_ab(2'b00, c), 1'b1, 1'b0}) begin
                bad++; $display("FAIL enter_phase%0d: got %b expected %b", c, {a1, b1, busy1, done1}, {exp_ab(2'b00, c), 1'b1, 1'b0});
            end
        end
        step();
        total++;
        if ({a1, b1, busy1, done1, dk1, ec1, xc1, r1} !== {2'b00, 1'b0, 1'b1, 2'b00, 3'd1, 3'd0, 1'b1}) begin
            bad++; $display("FAIL enter_done: got %h expected %h", {a1, b1, busy1, done1, dk1, ec1, xc1, r1}, {2'b00, 1'b0, 1'b1, 2'b00, 3'd1, 3'd0, 1'b1});
        end
        step();
        total++;
        if (done1 !== 1'b0) begin
            bad++; $display("FAIL enter_done_one_cycle: got %b expected 0", done1);
        end
    endtask

    task automatic test_back_to_back;
        logic [1:0] kinds [4];
        logic [2:0] exp_en;
        logic [2:0] exp_ex;
        kinds[0] = 2'b00; kinds[1] = 2'b00; kinds[2] = 2'b00; kinds[3] = 2'b01;
        exp_en = 3'd1; exp_ex = 3'd0;
        v1 = 1'b1; k1 = kinds[0];
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 5; c++) begin
                step();
                if (c == 1) k1 = 2'b11;
                total++;
                if (c < 4) begin
                    if ({a1, b1, busy1, done1} !== {exp_ab(kinds[p], c), 1'b1, 1'b0}) begin
                        bad++; $display("FAIL b2b_p%0d_c%0d: got %b expected %b", p, c, {a1, b1, busy1, done1}, {exp_ab(kinds[p], c), 1'b1, 1'b0});
                    end
                end else begin
                    if (kinds[p] == 2'b00) exp_en = exp_en + 3'd1;
                    else exp_ex = exp_ex + 3'd1;
                    if ({a1, b1, busy1, done1, dk1, ec1, xc1, r1} !== {2'b00, 1'b0, 1'b1, kinds[p], exp_en, exp_ex, 1'b1}) begin
                        bad++; $display("FAIL b2b_done_p%0d: got %h expected %h", p, {a1, b1, busy1, done1, dk1, ec1, xc1, r1}, {2'b00, 1'b0, 1'b1, kinds[p], exp_en, exp_ex, 1'b1});
                    end
                    if (p < 3) k1 = kinds[p+1];
                    else v1 = 1'b0;
                end
            end
        end
    endtask

    task automatic test_balk;
        logic [1:0] kinds [2];
        kinds[0] = 2'b10; kinds[1] = 2'b11;
        v1 = 1'b1; k1 = kinds[0];
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < 5; c++) begin
                step();
                total++;
                if (c < 4) begin
                    if ({a1, b1, busy1, done1} !== {exp_ab(kinds[p], c), 1'b1, 1'b0}) begin
                        bad++; $display("FAIL balk_p%0d_c%0d: got %b expected %b", p, c, {a1, b1, busy1, done1}, {exp_ab(kinds[p], c), 1'b1, 1'b0});
                    end
                end else begin
                    if ({a1, b1, busy1, done1, dk1, ec1, xc1} !== {2'b00, 1'b0, 1'b1, kinds[p], 3'd4, 3'd1}) begin
                        bad++; $display("FAIL balk_done_p%0d: got %h expected %h", p, {a1, b1, busy1, done1, dk1, ec1, xc1}, {2'b00, 1'b0, 1'b1, kinds[p], 3'd4, 3'd1});
                    end
                    if (p == 0) k1 = kinds[1];
                    else v1 = 1'b0;
                end
            end
        end
    endtask

    task automatic test_wrap;
        logic [2:0] exp_en;
        int ph;
        exp_en = 3'd0;
        v2 = 1'b1; k2 = 2'b00;
        for (int n = 0; n < 8; n++) begin
            for (int c = 0; c < 12; c++) begin
                step();
                total++;
                if (c < 11) begin
                    ph = (c < 9) ? (c / 3) : 3;
                    if ({a2, b2, busy2, done2} !== {exp_ab(2'b00, ph), 1'b1, 1'b0}) begin
                        bad++; $display("FAIL wrap_n%0d_c%0d: got %b expected %b", n, c, {a2, b2, busy2, done2}, {exp_ab(2'b00, ph), 1'b1, 1'b0});
                    end
                end else begin
                    exp_en = exp_en + 3'd1;
                    if ({a2, b2, busy2, done2, dk2, ec2, xc2} !== {2'b00, 1'b0, 1'b1, 2'b00, exp_en, 3'd0}) begin
                        bad++; $display("FAIL wrap_done_n%0d: got %h expected %h", n, {a2, b2, busy2, done2, dk2, ec2, xc2}, {2'b00, 1'b0, 1'b1, 2'b00, exp_en, 3'd0});
                    end
                    if (n == 7) begin
                        v2 = 1'b0;
                        total++;
                        if (ec2 !== 3'd0) begin
                            bad++; $display("FAIL wrap_to_zero: got %0d expected 0", ec2);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        v1 = 1'b1; k1 = 2'b00;
        step();
        v1 = 1'b0;
        step();
        total++;
        if ({a1, b1, busy1} !== 3'b111) begin
            bad++; $display("FAIL mid_p2: got %b expected 111", {a1, b1, busy1});
        end
        reset = 1'b1; v1 = 1'b1; k1 = 2'b01;
        for (int c = 0; c < 2; c++) begin
            step();
            total++;
            if ({a1, b1, busy1, done1, ec1, xc1, r1} !== {2'b00, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0}) begin
                bad++; $display("FAIL mid_reset_c%0d: got %h expected 0", c, {a1, b1, busy1, done1, ec1, xc1, r1});
            end
        end
        reset = 1'b0;
        #1;
        total++;
        if (r1 !== 1'b1) begin
            bad++; $display("FAIL mid_ready_after_release: got %b expected 1", r1);
        end
        for (int c = 0; c < 4; c++) begin
            step();
            if (c == 0) v1 = 1'b0;
            total++;
            if ({a1, b1, busy1, done1} !== {exp_ab(2'b01, c), 1'b1, 1'b0}) begin
                bad++; $display("FAIL mid_exit_c%0d: got %b expected %b", c, {a1, b1, busy1, done1}, {exp_ab(2'b01, c), 1'b1, 1'b0});
            end
        end
        step();
        total++;
        if ({busy1, done1, dk1, ec1, xc1} !== {1'b0, 1'b1, 2'b01, 3'd0, 3'd1}) begin
            bad++; $display("FAIL mid_exit_done: got %h expected %h", {busy1, done1, dk1, ec1, xc1}, {1'b0, 1'b1, 2'b01, 3'd0, 3'd1});
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_enter();
        test_back_to_back();
        test_balk();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
